// File: rtl/pattern_serializer_pkg.sv
// Shared definitions for the pattern serializer: FSM encoding, power-up
// pattern table contents and a small length clamp helper.
package serializer_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam logic [15:0] DEF_PAT0 = 16'hABCD;
    localparam int          DEF_LEN0 = 16;
    localparam logic [87:0] DEF_PAT1 = 88'h123456789ABCDEF1234567;
    localparam int          DEF_LEN1 = 88;

    // Limit a length to what the pattern register can hold.
    function automatic int clamp_len(input int len, input int max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/pattern_serializer_if.sv
// Control, load and serial-output bundle of the pattern serializer.
interface pattern_serializer_if #(
    parameter int CH_W    = 1,
    parameter int LEN_W   = 7,
    parameter int MAX_LEN = 88
);
    logic               START;
    logic [CH_W-1:0]    CH_SEL;
    logic               LOOP;
    logic               STOP;
    logic               LD_EN;
    logic [CH_W-1:0]    LD_CH;
    logic [LEN_W-1:0]   LD_LEN;
    logic [MAX_LEN-1:0] LD_DATA;
    logic               BUSY;
    logic               DONE;
    logic               SER_OUT;
    logic               SER_VALID;

    modport master (
        output START, CH_SEL, LOOP, STOP, LD_EN, LD_CH, LD_LEN, LD_DATA,
        input  BUSY, DONE, SER_OUT, SER_VALID
    );

    modport slave (
        input  START, CH_SEL, LOOP, STOP, LD_EN, LD_CH, LD_LEN, LD_DATA,
        output BUSY, DONE, SER_OUT, SER_VALID
    );
endinterface

// File: rtl/pattern_serializer_bank.sv
// Pattern table: one right-aligned pattern plus length per channel.
// The table is padded to a power of two so any index can be read; padding
// entries read as length 0, which the player treats as "nothing to send".
module pattern_bank
    import serializer_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int MAX_LEN = 88,
    parameter int CH_W    = 1,
    parameter int LEN_W   = 7
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               wr_en,
    input  logic [CH_W-1:0]    wr_ch,
    input  logic [LEN_W-1:0]   wr_len,
    input  logic [MAX_LEN-1:0] wr_data,
    input  logic [CH_W-1:0]    rd_ch,
    output logic [MAX_LEN-1:0] rd_pat,
    output logic [LEN_W-1:0]   rd_len
);
    localparam int DEPTH = 2 ** CH_W;

    logic [DEPTH-1:0][MAX_LEN-1:0] pat_all_s;
    logic [DEPTH-1:0][LEN_W-1:0]   len_all_s;
    logic [LEN_W-1:0]              wr_len_clamped_s;

    // Over-long load lengths saturate at the register capacity.
    always_comb begin
        if (wr_len > LEN_W'(MAX_LEN)) begin
            wr_len_clamped_s = LEN_W'(MAX_LEN);
        end else begin
            wr_len_clamped_s = wr_len;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        if (i < NUM_CH) begin : g_live
            localparam logic [MAX_LEN-1:0] DEF_PAT =
                (i == 0) ? MAX_LEN'(DEF_PAT0) :
                (i == 1) ? MAX_LEN'(DEF_PAT1) : {MAX_LEN{1'b0}};
            localparam int DEF_LEN = clamp_len(
                (i == 0) ? DEF_LEN0 : (i == 1) ? DEF_LEN1 : 0, MAX_LEN);

            logic [MAX_LEN-1:0] pat_r;
            logic [LEN_W-1:0]   len_r;

            // Entry storage: defaults on reset, overwritten by a matching load.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    pat_r <= DEF_PAT;
                    len_r <= LEN_W'(DEF_LEN);
                end else if (wr_en && (wr_ch == CH_W'(i))) begin
                    pat_r <= wr_data;
                    len_r <= wr_len_clamped_s;
                end
            end

            assign pat_all_s[i] = pat_r;
            assign len_all_s[i] = len_r;
        end else begin : g_pad
            assign pat_all_s[i] = {MAX_LEN{1'b0}};
            assign len_all_s[i] = {LEN_W{1'b0}};
        end
    end

    assign rd_pat = pat_all_s[rd_ch];
    assign rd_len = len_all_s[rd_ch];

endmodule

// File: rtl/pattern_serializer.sv
// Multi-channel MSB-first pattern serializer. A START in IDLE copies the
// selected channel into a left-aligned working register; one bit leaves per
// cycle while a down-counter tracks the bits still to come.
module pattern_serializer
    import serializer_pkg::*;
#(
    parameter int NUM_CH  = 2,
    parameter int MAX_LEN = 88,
    parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               CLK,
    input  logic               RST,
    pattern_serializer_if.slave bus
);
    state_e             state_r, state_n;
    logic [MAX_LEN-1:0] shreg_r, shreg_n;
    logic [LEN_W-1:0]   cnt_r, cnt_n;
    logic [CH_W-1:0]    ch_r, ch_n;
    logic               busy_r, busy_n;
    logic               done_r, done_n;
    logic               valid_r, valid_n;
    logic               ser_r, ser_n;

    logic [CH_W-1:0]    rd_ch_s;
    logic [MAX_LEN-1:0] rd_pat_s;
    logic [LEN_W-1:0]   rd_len_s;
    logic [MAX_LEN-1:0] aligned_s;

    // In IDLE the table is read at CH_SEL, during playback at the latched channel.
    assign rd_ch_s   = (state_r == ST_IDLE) ? bus.CH_SEL : ch_r;
    assign aligned_s = rd_pat_s << (LEN_W'(MAX_LEN) - rd_len_s);

    pattern_bank #(
        .NUM_CH  (NUM_CH),
        .MAX_LEN (MAX_LEN),
        .CH_W    (CH_W),
        .LEN_W   (LEN_W)
    ) u_bank (
        .CLK     (CLK),
        .RST     (RST),
        .wr_en   (bus.LD_EN),
        .wr_ch   (bus.LD_CH),
        .wr_len  (bus.LD_LEN),
        .wr_data (bus.LD_DATA),
        .rd_ch   (rd_ch_s),
        .rd_pat  (rd_pat_s),
        .rd_len  (rd_len_s)
    );

    // Next-state and next-output logic; STOP wins over LOOP and START.
    always_comb begin
        state_n = state_r;
        shreg_n = shreg_r;
        cnt_n   = cnt_r;
        ch_n    = ch_r;
        done_n  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.START && !bus.STOP) begin
                    if (rd_len_s != {LEN_W{1'b0}}) begin
                        state_n = ST_SHIFT;
                        shreg_n = aligned_s;
                        cnt_n   = rd_len_s - LEN_W'(1);
                        ch_n    = rd_ch_s;
                    end else begin
                        done_n  = 1'b1;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (bus.STOP) begin
                    state_n = ST_IDLE;
                end else if (cnt_r != {LEN_W{1'b0}}) begin
                    shreg_n = {shreg_r[MAX_LEN-2:0], 1'b0};
                    cnt_n   = cnt_r - LEN_W'(1);
                end else if (bus.LOOP && (rd_len_s != {LEN_W{1'b0}})) begin
                    shreg_n = aligned_s;
                    cnt_n   = rd_len_s - LEN_W'(1);
                end else begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
        valid_n = (state_n == ST_SHIFT);
        busy_n  = valid_n;
        ser_n   = valid_n & shreg_n[MAX_LEN-1];
    end

    // State, working copy and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
            shreg_r <= {MAX_LEN{1'b0}};
            cnt_r   <= {LEN_W{1'b0}};
            ch_r    <= {CH_W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            valid_r <= 1'b0;
            ser_r   <= 1'b0;
        end else begin
            state_r <= state_n;
            shreg_r <= shreg_n;
            cnt_r   <= cnt_n;
            ch_r    <= ch_n;
            busy_r  <= busy_n;
            done_r  <= done_n;
            valid_r <= valid_n;
            ser_r   <= ser_n;
        end
    end

    assign bus.BUSY      = busy_r;
    assign bus.DONE      = done_r;
    assign bus.SER_OUT   = ser_r;
    assign bus.SER_VALID = valid_r;

endmodule
